// File: rtl/page_nav_ctrl_if.sv
// Interface bundling the page controller's key, sync and status signals.
// The controller connects through the slave modport; whatever drives the
// keys and v_sync, and watches the page outputs, uses the master modport.
interface page_nav_ctrl_if;
    logic [15:0] btns;          // matrix-key levels, 1 = pressed, asynchronous
    logic [4:0]  keys;          // PS2 levels {space,down,right,left,up}, asynchronous
    logic        v_sync;        // vertical sync from the VGA timing block
    logic [1:0]  page_status;   // selected page, select for the page pixel mux
    logic [3:0]  input_en;      // one-hot input grant to the ctrl_transfer gates
    logic        switch_pulse;  // one-cycle pulse when page_status changes
    logic        busy;          // request pending or post-switch hold active

    modport master (
        output btns,
        output keys,
        output v_sync,
        input  page_status,
        input  input_en,
        input  switch_pulse,
        input  busy
    );

    modport slave (
        input  btns,
        input  keys,
        input  v_sync,
        output page_status,
        output input_en,
        output switch_pulse,
        output busy
    );
endinterface

// File: rtl/page_nav_ctrl.sv
// page_nav_ctrl: turns debounced next/previous key presses into page changes
// for the VGA page multiplexer. A change is applied only on a frame tick
// (synchronized v_sync entering its active level), so frames never tear.
// After a switch all input grants stay low for HOLD_FRAMES frame ticks and
// until every debounced nav level is released.
//
// Optional feature macro: PAGE_NAV_PS2_EN
//   defined   - PS2 right arrow (keys[2]) is merged into "next" and PS2 left
//               arrow (keys[1]) into "prev" ahead of synchronization/debounce.
//   undefined - keys is ignored.
module page_nav_ctrl #(
    parameter int NUM_PAGES       = 3,
    parameter int INIT_PAGE       = 0,
    parameter int NEXT_BTN        = 0,
    parameter int PREV_BTN        = 1,
    parameter int DEBOUNCE_CYCLES = 65535,
    parameter int HOLD_FRAMES     = 2,
    parameter bit VSYNC_ACTIVE    = 1'b0
) (
    input  logic            vga_clk,
    input  logic            vga_rst,
    page_nav_ctrl_if.slave  bus
);

    localparam logic [1:0]  LAST_PAGE = 2'(NUM_PAGES - 1);
    localparam logic [1:0]  INIT_P    = 2'(INIT_PAGE);
    localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  HOLD_INIT = 8'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        HOLD    = 2'd2
    } state_t;

    function automatic logic [3:0] onehot(input logic [1:0] p);
        return 4'b0001 << p;
    endfunction

    function automatic logic [1:0] page_next(input logic [1:0] p);
        return (p == LAST_PAGE) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [1:0] page_prev(input logic [1:0] p);
        return (p == 2'd0) ? LAST_PAGE : p - 2'd1;
    endfunction

    // Nav sources, bit 0 = next, bit 1 = prev.
    logic [1:0] nav_raw;

`ifdef PAGE_NAV_PS2_EN
    assign nav_raw = {bus.btns[PREV_BTN] | bus.keys[1],
                      bus.btns[NEXT_BTN] | bus.keys[2]};
    logic unused_keys;
    assign unused_keys = ^{bus.keys[4:3], bus.keys[0]};
`else
    assign nav_raw = {bus.btns[PREV_BTN], bus.btns[NEXT_BTN]};
    logic unused_keys;
    assign unused_keys = ^bus.keys;
`endif

    // Only the two nav buttons are consumed; the other matrix keys belong to
    // the pages themselves.
    logic unused_btns;
    assign unused_btns = ^bus.btns;

    logic [1:0]  nav_s1_q, nav_s2_q;
    logic [1:0]  deb_q, deb_d;
    logic [15:0] cnt_q [2];
    logic [15:0] cnt_d [2];
    logic [1:0]  press;
    logic        vs_s1_q, vs_s2_q, vs_prev_q;
    logic        frame_tick;

    state_t      state_q, state_d;
    logic        dir_next_q, dir_next_d;
    logic [1:0]  page_q, page_d;
    logic [3:0]  en_q, en_d;
    logic        pulse_q, pulse_d;
    logic        busy_q, busy_d;
    logic [7:0]  hold_q, hold_d;

    assign frame_tick = (vs_s2_q == VSYNC_ACTIVE) && (vs_prev_q != VSYNC_ACTIVE);

    // Debounce: a level change is accepted after DEBOUNCE_CYCLES consecutive
    // differing cycles; the rising acceptance is the press event.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            press[i] = 1'b0;
            if (nav_s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                    press[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Synchronizers, frame-edge history and debounce state.
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            nav_s1_q  <= '0;
            nav_s2_q  <= '0;
            deb_q     <= '0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
            vs_s1_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            nav_s1_q  <= nav_raw;
            nav_s2_q  <= nav_s1_q;
            deb_q     <= deb_d;
            cnt_q[0]  <= cnt_d[0];
            cnt_q[1]  <= cnt_d[1];
            vs_s1_q   <= bus.v_sync;
            vs_s2_q   <= vs_s1_q;
            vs_prev_q <= vs_s2_q;
        end
    end

    // Page FSM next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        dir_next_d = dir_next_q;
        page_d     = page_q;
        en_d       = en_q;
        pulse_d    = 1'b0;
        busy_d     = busy_q;
        hold_d     = hold_q;
        case (state_q)
            IDLE: begin
                // Simultaneous next+prev is ambiguous and dropped. A tick in
                // the same cycle is not consumed: the switch waits a frame.
                if (press[0] ^ press[1]) begin
                    dir_next_d = press[0];
                    state_d    = PENDING;
                    busy_d     = 1'b1;
                end
            end
            PENDING: begin
                if (frame_tick) begin
                    page_d  = dir_next_q ? page_next(page_q) : page_prev(page_q);
                    pulse_d = 1'b1;
                    en_d    = 4'b0000;
                    hold_d  = HOLD_INIT;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                en_d = 4'b0000;
                if (hold_q != 8'd0) begin
                    if (frame_tick) begin
                        hold_d = hold_q - 8'd1;
                    end
                end else if (deb_q == 2'b00) begin
                    en_d    = onehot(page_q);
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = onehot(page_q);
                busy_d  = 1'b0;
            end
        endcase
    end

    // Page FSM state and output registers.
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            state_q    <= IDLE;
            dir_next_q <= 1'b0;
            page_q     <= INIT_P;
            en_q       <= onehot(INIT_P);
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            dir_next_q <= dir_next_d;
            page_q     <= page_d;
            en_q       <= en_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            hold_q     <= hold_d;
        end
    end

    assign bus.page_status  = page_q;
    assign bus.input_en     = en_q;
    assign bus.switch_pulse = pulse_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_page_nav_ctrl.sv
// Directed bench for page_nav_ctrl: DEBOUNCE_CYCLES=4, HOLD_FRAMES=2,
// NUM_PAGES=3, v_sync active low.
module tb_page_nav_ctrl;

    logic vga_clk = 1'b0;
    logic vga_rst;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   pulses = 0;
    int   p0;

    page_nav_ctrl_if bus ();

    page_nav_ctrl #(
        .NUM_PAGES       (3),
        .INIT_PAGE       (0),
        .NEXT_BTN        (0),
        .PREV_BTN        (1),
        .DEBOUNCE_CYCLES (4),
        .HOLD_FRAMES     (2),
        .VSYNC_ACTIVE    (1'b0)
    ) dut (
        .vga_clk (vga_clk),
        .vga_rst (vga_rst),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    // Count switch pulses as seen at each rising edge.
    always @(posedge vga_clk) begin
        if (bus.switch_pulse) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge vga_clk);
        #1;
    endtask

    // One frame: v_sync low (active) for 4 cycles, then back high.
    task automatic frame();
        bus.v_sync = 1'b0;
        cyc(4);
        bus.v_sync = 1'b1;
        cyc(4);
    endtask

    logic [1:0] exp_page [3] = '{2'd1, 2'd2, 2'd0};
    logic [3:0] exp_en   [3] = '{4'b0010, 4'b0100, 4'b0001};
    logic [3:0] old_en   [3] = '{4'b0001, 4'b0010, 4'b0100};

    initial begin
        bus.btns   = 16'hFFFF;
        bus.keys   = 5'b0;
        bus.v_sync = 1'b1;
        vga_rst    = 1'b1;
        cyc(3);
        chk("rst_page",  16'(bus.page_status),  16'd0);
        chk("rst_en",    16'(bus.input_en),     16'b0001);
        chk("rst_busy",  16'(bus.busy),         16'd0);
        chk("rst_pulse", 16'(bus.switch_pulse), 16'd0);
        bus.btns = 16'h0000;
        cyc(2);
        vga_rst = 1'b0;
        cyc(4);

        // Next with wrap: 0 -> 1 -> 2 -> 0.
        for (int k = 0; k < 3; k++) begin
            p0 = pulses;
            bus.btns = 16'h0001;
            cyc(10);
            chk("nx_pend_busy", 16'(bus.busy),     16'd1);
            chk("nx_pend_en",   16'(bus.input_en), 16'(old_en[k]));
            frame();
            chk("nx_page",      16'(bus.page_status), 16'(exp_page[k]));
            chk("nx_en_off",    16'(bus.input_en),    16'd0);
            chk("nx_pulses",    16'(pulses - p0),     16'd1);
            bus.btns = 16'h0000;
            cyc(10);
            chk("nx_hold_en0",  16'(bus.input_en), 16'd0);
            frame();
            chk("nx_hold_en1",  16'(bus.input_en), 16'd0);
            frame();
            chk("nx_rel_en",    16'(bus.input_en), 16'(exp_en[k]));
            chk("nx_rel_busy",  16'(bus.busy),     16'd0);
        end

        // Glitch on prev: 3 cycles is too short to be accepted.
        bus.btns = 16'h0002;
        cyc(3);
        bus.btns = 16'h0000;
        cyc(8);
        chk("gl_busy", 16'(bus.busy), 16'd0);
        frame();
        chk("gl_page", 16'(bus.page_status), 16'd0);

        // Prev with wrap: 0 -> 2.
        bus.btns = 16'h0002;
        cyc(10);
        frame();
        chk("pv_page", 16'(bus.page_status), 16'd2);
        bus.btns = 16'h0000;
        cyc(10);
        frame();
        frame();
        chk("pv_en", 16'(bus.input_en), 16'b0100);

        // Next and prev together: ignored.
        bus.btns = 16'h0003;
        cyc(10);
        chk("both_busy", 16'(bus.busy), 16'd0);
        frame();
        chk("both_page", 16'(bus.page_status), 16'd2);
        bus.btns = 16'h0000;
        cyc(10);
        chk("both_en", 16'(bus.input_en), 16'b0100);

        // Two next presses before a frame tick: a single step 2 -> 0.
        p0 = pulses;
        bus.btns = 16'h0001;
        cyc(10);
        bus.btns = 16'h0000;
        cyc(10);
        bus.btns = 16'h0001;
        cyc(10);
        bus.btns = 16'h0000;
        cyc(10);
        frame();
        chk("dbl_page", 16'(bus.page_status), 16'd0);
        frame();
        frame();
        chk("dbl_pulses", 16'(pulses - p0), 16'd1);
        chk("dbl_en",     16'(bus.input_en), 16'b0001);

        // Held key keeps the hold beyond HOLD_FRAMES: 0 -> 1.
        bus.btns = 16'h0001;
        cyc(10);
        frame();
        chk("held_page", 16'(bus.page_status), 16'd1);
        repeat (5) frame();
        chk("held_en",   16'(bus.input_en), 16'd0);
        chk("held_busy", 16'(bus.busy),     16'd1);
        bus.btns = 16'h0000;
        cyc(10);
        chk("held_rel_en",   16'(bus.input_en), 16'b0010);
        chk("held_rel_busy", 16'(bus.busy),     16'd0);

        // Reset while PENDING drops the request.
        bus.btns = 16'h0001;
        cyc(10);
        chk("mr_busy_pre", 16'(bus.busy), 16'd1);
        bus.btns = 16'h0000;
        vga_rst = 1'b1;
        cyc(2);
        vga_rst = 1'b0;
        cyc(1);
        chk("mr_page", 16'(bus.page_status), 16'd0);
        chk("mr_en",   16'(bus.input_en),    16'b0001);
        chk("mr_busy", 16'(bus.busy),        16'd0);
        p0 = pulses;
        frame();
        chk("mr_tick_page", 16'(bus.page_status), 16'd0);
        chk("mr_tick_pls",  16'(pulses - p0),     16'd0);

        // PS2 right arrow.
        bus.keys = 5'b00100;
        cyc(10);
        frame();
        bus.keys = 5'b00000;
        cyc(10);
        frame();
        frame();
`ifdef PAGE_NAV_PS2_EN
        chk("ps2_page", 16'(bus.page_status), 16'd1);
        chk("ps2_en",   16'(bus.input_en),    16'b0010);
`else
        chk("ps2_page", 16'(bus.page_status), 16'd0);
        chk("ps2_en",   16'(bus.input_en),    16'b0001);
`endif
        chk("ps2_busy", 16'(bus.busy), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/page_nav_ctrl.md
Name: page_nav_ctrl

Overview:
- Page controller for the VGA page multiplexer. Turns debounced matrix-key presses (and, optionally, PS2 arrows) into next/previous page requests.
- Applies a page change only at a frame boundary, taken from the v_sync edge, so frames never tear.
- Grants the shared key inputs to exactly one page through one-hot enables, which drive the ctrl_transfer gates.
- Its page_status output is the select for the page pixel mux.

Parameters:
- NUM_PAGES, 3, number of pages; valid range 2..4.
- INIT_PAGE, 0, page selected after reset.
- NEXT_BTN, 0, index into btns used as "next page".
- PREV_BTN, 1, index into btns used as "previous page".
- DEBOUNCE_CYCLES, 65535, consecutive stable vga_clk cycles needed to accept a level change; 16-bit counter.
- HOLD_FRAMES, 2, frame ticks during which all input enables stay low after a switch.
- VSYNC_ACTIVE, 0, active level of v_sync.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- vga_rst  in  1  synchronous, active-high reset.
- btns  in  16  matrix-key levels, 1 = pressed, asynchronous to vga_clk.
- keys  in  5  PS2 levels {space,down,right,left,up}, asynchronous.
- v_sync  in  1  vertical sync from the VGA timing block.
- page_status  out  2  selected page, 0..NUM_PAGES-1.
- input_en  out  4  one-hot input grant; bit i enables page i's ctrl_transfer.
- switch_pulse  out  1  one-cycle pulse in the cycle page_status changes.
- busy  out  1  high while a request is pending or the hold is active.

Behaviour:
- Reset (vga_rst=1 at a rising edge) sets the following on the next edge:
  - page_status=INIT_PAGE, input_en=1<<INIT_PAGE, switch_pulse=0, busy=0, FSM=IDLE.
  - Synchronizers, debounced levels and counters cleared; any pending request dropped.
  - Reset mid-PENDING or mid-HOLD aborts cleanly.
- Synchronization: every used asynchronous bit (btns[NEXT_BTN], btns[PREV_BTN], v_sync, and keys when enabled) passes through a 2-flop synchronizer.
- Debounce, per nav input:
  - The counter increments while the synchronized level differs from the debounced level, and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A 0->1 flip of the debounced level produces a one-cycle press event.
- Frame tick: one-cycle pulse on the synchronized v_sync transition into VSYNC_ACTIVE.
- FSM state IDLE:
  - A next or prev press latches the direction and moves to PENDING; busy=1.
  - Next and prev pressed in the same cycle: both ignored, stay IDLE.
- FSM state PENDING:
  - Further presses are ignored; only one request is queued.
  - On a frame tick, page_status updates and the FSM moves to HOLD.
  - Next: NUM_PAGES-1 wraps to 0, otherwise +1. Prev: 0 wraps to NUM_PAGES-1, otherwise -1.
  - Same edge: switch_pulse=1, input_en=0, hold counter=HOLD_FRAMES.
- FSM state HOLD:
  - input_en=0 and presses are ignored.
  - Each frame tick decrements the hold counter.
  - When the counter is 0 and all debounced nav levels are 0, the FSM goes to IDLE: input_en=1<<page_status, busy=0.
  - A key held longer than the hold keeps HOLD until it is released.
- Output timing:
  - All outputs are registered.
  - page_status changes exactly 1 cycle after the frame-tick pulse.
  - input_en bits at or above NUM_PAGES are always 0.
  - page_status never leaves the range 0..NUM_PAGES-1.
- Frame tick and press in the same cycle while IDLE: the press is latched; the tick is not consumed, so the switch waits for the next frame tick.

Optional Feature:
- Macro: PAGE_NAV_PS2_EN.
- Defined: keys[2] (right) is ORed into the next source and keys[1] (left) into the prev source, before debounce. Each merged source has its own synchronizer and debouncer, and HOLD release also waits for the merged levels.
- Undefined: keys is unused and its logic is not generated. Behaviour is otherwise identical.

Test Plan:
- Bench runs with DEBOUNCE_CYCLES=4, HOLD_FRAMES=2 and NUM_PAGES=3 unless stated.
- Reset: assert vga_rst for 3 cycles with btns=16'hFFFF -> page_status=0, input_en=4'b0001, busy=0, switch_pulse=0.
- Next with wrap:
  - Three clean presses of btns[0] (10 cycles each), each followed by a v_sync tick and a release -> page_status goes 1, 2, 0.
  - Exactly one switch_pulse per switch; input_en=0 for 2 frame ticks, then one-hot of the new page.
- Glitch rejection and prev wrap:
  - btns[1] high for 3 cycles -> no press event, page_status stays 0.
  - btns[1] high for 10 cycles, then a frame tick -> page_status=2.
- Simultaneous and extra presses:
  - btns[0] and btns[1] stable together -> no change, busy=0.
  - Next pressed twice before a frame tick -> a single step, page_status +1.
- Held key:
  - btns[0] held through 5 frame ticks after a switch -> input_en stays 0 and busy=1.
  - Release -> after the debounce, input_en=one-hot of the page and busy=0.
- Mid-operation reset and PS2 (PS2 part with PAGE_NAV_PS2_EN defined):
  - vga_rst during PENDING -> page_status=0 and no switch on the next tick.
  - keys[2] press plus frame tick -> page_status=1; undefined -> unchanged.
